// File: rtl/y86_pkg.sv
// Shared Y86-64 core definitions: icodes, status codes, register ids and the
// pipeline-controller state encoding and output bundle.
package y86_pkg;

   localparam logic [3:0] I_HALT   = 4'h0;
   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_RRMOVQ = 4'h2;
   localparam logic [3:0] I_IRMOVQ = 4'h3;
   localparam logic [3:0] I_RMMOVQ = 4'h4;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_JXX    = 4'h7;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;

   localparam logic [1:0] S_AOK = 2'd0;
   localparam logic [1:0] S_HLT = 2'd1;
   localparam logic [1:0] S_ADR = 2'd2;
   localparam logic [1:0] S_INS = 2'd3;

   localparam logic [3:0] RNONE = 4'hF;

   typedef enum logic [1:0] {
      ST_INIT   = 2'd0,
      ST_RUN    = 2'd1,
      ST_DRAIN  = 2'd2,
      ST_HALTED = 2'd3
   } ctrl_state_e;

   typedef struct packed {
      logic f_stall;
      logic d_stall;
      logic d_bubble;
      logic e_bubble;
      logic m_bubble;
      logic w_stall;
      logic set_cc;
   } ctrl_out_t;

   function automatic logic status_ok(input logic [1:0] status);
      return status == S_AOK;
   endfunction

endpackage

// File: rtl/pipe_hazard_detect.sv
// Combinational hazard terms for the five-stage pipeline: load/use,
// return-in-flight and jump misprediction.
module pipe_hazard_detect
   import y86_pkg::*;
(
   input  logic [3:0] D_icode_i,
   input  logic [3:0] d_srcA_i,
   input  logic [3:0] d_srcB_i,
   input  logic [3:0] E_icode_i,
   input  logic [3:0] E_dstM_i,
   input  logic       e_cond_i,
   input  logic [3:0] M_icode_i,
   output logic       loaduse_o,
   output logic       ret_o,
   output logic       mispred_o
);

   logic e_is_load;
   logic dstm_hit;

   assign e_is_load = (E_icode_i == I_MRMOVQ) || (E_icode_i == I_POPQ);
   // RNONE never names a real register, so it must not count as a match.
   assign dstm_hit  = (E_dstM_i != RNONE) &&
                      ((E_dstM_i == d_srcA_i) || (E_dstM_i == d_srcB_i));
   assign loaduse_o = e_is_load && dstm_hit;

   assign ret_o     = (D_icode_i == I_RET) || (E_icode_i == I_RET) ||
                      (M_icode_i == I_RET);

   assign mispred_o = (E_icode_i == I_JXX) && !e_cond_i;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: stall/bubble/set_cc generation and run/drain/halt FSM.
// Optional saturating performance counters under macro PIPE_CTRL_PERF_EN.
module pipe_ctrl
   import y86_pkg::*;
`ifdef PIPE_CTRL_PERF_EN
#(
   parameter int CNT_W = 32
)
`endif
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  D_icode,
   input  logic [3:0]  d_srcA,
   input  logic [3:0]  d_srcB,
   input  logic [3:0]  E_icode,
   input  logic [3:0]  E_dstM,
   input  logic        e_cond,
   input  logic [3:0]  M_icode,
   input  logic [1:0]  m_status,
   input  logic [1:0]  W_status,
   output logic        F_stall,
   output logic        D_stall,
   output logic        D_bubble,
   output logic        E_bubble,
   output logic        M_bubble,
   output logic        W_stall,
   output logic        set_cc,
   output logic        halted,
   output logic [1:0]  halt_code,
   output ctrl_state_e dbg_state_o
`ifdef PIPE_CTRL_PERF_EN
   ,
   output logic [CNT_W-1:0] perf_stall,
   output logic [CNT_W-1:0] perf_mispred,
   output logic [CNT_W-1:0] perf_ret,
   output logic [CNT_W-1:0] perf_cycles
`endif
);

   ctrl_state_e state_q, state_d;
   logic [1:0]  halt_code_q, halt_code_d;
   logic        loaduse, ret, mispred;
   logic        m_exc, w_exc;
   ctrl_out_t   run_out, ctrl_out;

   pipe_hazard_detect u_hazard (
      .D_icode_i (D_icode),
      .d_srcA_i  (d_srcA),
      .d_srcB_i  (d_srcB),
      .E_icode_i (E_icode),
      .E_dstM_i  (E_dstM),
      .e_cond_i  (e_cond),
      .M_icode_i (M_icode),
      .loaduse_o (loaduse),
      .ret_o     (ret),
      .mispred_o (mispred)
   );

   assign m_exc = !status_ok(m_status);
   assign w_exc = !status_ok(W_status);

   always_comb begin
      run_out          = '0;
      run_out.f_stall  = loaduse | ret;
      run_out.d_stall  = loaduse;
      // A load/use stall must keep the instruction in D, so it beats the ret bubble.
      run_out.d_bubble = mispred | (ret & ~loaduse);
      run_out.e_bubble = mispred | loaduse;
      run_out.m_bubble = m_exc | w_exc;
      run_out.w_stall  = w_exc;
      run_out.set_cc   = (E_icode == I_OPQ) & ~m_exc & ~w_exc;
   end

   always_comb begin
      state_d     = state_q;
      halt_code_d = halt_code_q;
      ctrl_out    = run_out;
      case (state_q)
         ST_INIT: begin
            ctrl_out          = '0;
            ctrl_out.d_bubble = 1'b1;
            ctrl_out.e_bubble = 1'b1;
            ctrl_out.m_bubble = 1'b1;
            state_d           = ST_RUN;
         end
         ST_RUN: begin
            if (w_exc) begin
               state_d     = ST_HALTED;
               halt_code_d = W_status;
            end else if (m_exc) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            ctrl_out.set_cc   = 1'b0;
            ctrl_out.m_bubble = 1'b1;
            if (w_exc) begin
               state_d     = ST_HALTED;
               halt_code_d = W_status;
            end
         end
         ST_HALTED: begin
            ctrl_out          = '0;
            ctrl_out.f_stall  = 1'b1;
            ctrl_out.d_stall  = 1'b1;
            ctrl_out.e_bubble = 1'b1;
            ctrl_out.m_bubble = 1'b1;
            ctrl_out.w_stall  = 1'b1;
         end
         default: begin
            state_d = ST_INIT;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_INIT;
         halt_code_q <= S_AOK;
      end else begin
         state_q     <= state_d;
         halt_code_q <= halt_code_d;
      end
   end

   assign F_stall     = ctrl_out.f_stall;
   assign D_stall     = ctrl_out.d_stall;
   assign D_bubble    = ctrl_out.d_bubble;
   assign E_bubble    = ctrl_out.e_bubble;
   assign M_bubble    = ctrl_out.m_bubble;
   assign W_stall     = ctrl_out.w_stall;
   assign set_cc      = ctrl_out.set_cc;
   assign halted      = (state_q == ST_HALTED);
   assign halt_code   = halt_code_q;
   assign dbg_state_o = state_q;

`ifdef PIPE_CTRL_PERF_EN
   logic             cnt_en;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;
   logic [CNT_W-1:0] ret_cnt_q, ret_cnt_d;
   logic [CNT_W-1:0] cyc_cnt_q, cyc_cnt_d;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                input logic inc);
      return (inc && (v != '1)) ? v + CNT_W'(1) : v;
   endfunction

   // Counting covers only RUN and DRAIN, so values freeze once HALTED.
   assign cnt_en = (state_q == ST_RUN) || (state_q == ST_DRAIN);

   always_comb begin
      stall_cnt_d   = sat_inc(stall_cnt_q, cnt_en & loaduse);
      mispred_cnt_d = sat_inc(mispred_cnt_q, cnt_en & mispred);
      ret_cnt_d     = sat_inc(ret_cnt_q, cnt_en & ret & ~loaduse);
      cyc_cnt_d     = sat_inc(cyc_cnt_q, cnt_en);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q   <= '0;
         mispred_cnt_q <= '0;
         ret_cnt_q     <= '0;
         cyc_cnt_q     <= '0;
      end else begin
         stall_cnt_q   <= stall_cnt_d;
         mispred_cnt_q <= mispred_cnt_d;
         ret_cnt_q     <= ret_cnt_d;
         cyc_cnt_q     <= cyc_cnt_d;
      end
   end

   assign perf_stall   = stall_cnt_q;
   assign perf_mispred = mispred_cnt_q;
   assign perf_ret     = ret_cnt_q;
   assign perf_cycles  = cyc_cnt_q;
`else
   // Counter logic is compiled out; only the control path remains.
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: vector table, hand-written FSM sequences and
// randomized traffic against a rule-level reference model.
module tb_pipe_ctrl;
   import y86_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode;
   logic        e_cond;
   logic [1:0]  m_status, W_status;
   logic        F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc;
   logic        halted;
   logic [1:0]  halt_code;
   ctrl_state_e dbg_state;
`ifdef PIPE_CTRL_PERF_EN
   logic [3:0]  perf_stall, perf_mispred, perf_ret, perf_cycles;
`endif

   logic [6:0]  outs;
   assign outs = {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc};

   int n_checks = 0;
   int n_fail   = 0;

   // model of the controller's mode, kept as independent flags
   bit         mdl_init, mdl_drain, mdl_halted;
   logic [1:0] mdl_code;

   localparam logic [6:0] OUT_INIT = 7'b0011100;
   localparam logic [6:0] OUT_HALT = 7'b1101110;

   typedef struct packed {
      logic [3:0] d_icode;
      logic [3:0] srca;
      logic [3:0] srcb;
      logic [3:0] e_icode;
      logic [3:0] e_dstm;
      logic       cond;
      logic [3:0] m_icode;
      logic [6:0] exp;
   } vec_t;

   vec_t tbl [13];

   always #5 clk = ~clk;

`ifdef PIPE_CTRL_PERF_EN
   pipe_ctrl #(.CNT_W(4)) dut (
`else
   pipe_ctrl dut (
`endif
      .clk         (clk),
      .rst_n       (rst_n),
      .D_icode     (D_icode),
      .d_srcA      (d_srcA),
      .d_srcB      (d_srcB),
      .E_icode     (E_icode),
      .E_dstM      (E_dstM),
      .e_cond      (e_cond),
      .M_icode     (M_icode),
      .m_status    (m_status),
      .W_status    (W_status),
      .F_stall     (F_stall),
      .D_stall     (D_stall),
      .D_bubble    (D_bubble),
      .E_bubble    (E_bubble),
      .M_bubble    (M_bubble),
      .W_stall     (W_stall),
      .set_cc      (set_cc),
      .halted      (halted),
      .halt_code   (halt_code),
      .dbg_state_o (dbg_state)
`ifdef PIPE_CTRL_PERF_EN
      ,
      .perf_stall  (perf_stall),
      .perf_mispred(perf_mispred),
      .perf_ret    (perf_ret),
      .perf_cycles (perf_cycles)
`endif
   );

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
      end
   endtask

   function automatic vec_t mkv(input logic [3:0] d, input logic [3:0] sa, input logic [3:0] sb,
                                input logic [3:0] e, input logic [3:0] dm, input logic c,
                                input logic [3:0] m, input logic [6:0] exp);
      vec_t v;
      v.d_icode = d; v.srca = sa; v.srcb = sb; v.e_icode = e;
      v.e_dstm = dm; v.cond = c; v.m_icode = m; v.exp = exp;
      return v;
   endfunction

   task automatic set_nop();
      D_icode = I_NOP; d_srcA = RNONE; d_srcB = RNONE;
      E_icode = I_NOP; E_dstM = RNONE; e_cond = 1'b1;
      M_icode = I_NOP; m_status = S_AOK; W_status = S_AOK;
   endtask

   task automatic apply_vec(input vec_t v);
      D_icode = v.d_icode; d_srcA = v.srca; d_srcB = v.srcb;
      E_icode = v.e_icode; E_dstM = v.e_dstm; e_cond = v.cond;
      M_icode = v.m_icode; m_status = S_AOK; W_status = S_AOK;
   endtask

   task automatic rand_inputs();
      D_icode  = 4'($urandom_range(0, 11));
      d_srcA   = ($urandom_range(0, 3) == 0) ? RNONE : 4'($urandom_range(0, 4));
      d_srcB   = ($urandom_range(0, 3) == 0) ? RNONE : 4'($urandom_range(0, 4));
      E_icode  = 4'($urandom_range(0, 11));
      E_dstM   = ($urandom_range(0, 3) == 0) ? RNONE : 4'($urandom_range(0, 4));
      e_cond   = 1'($urandom_range(0, 1));
      M_icode  = 4'($urandom_range(0, 11));
      m_status = ($urandom_range(0, 19) == 0) ? 2'($urandom_range(1, 3)) : S_AOK;
      W_status = ($urandom_range(0, 24) == 0) ? 2'($urandom_range(1, 3)) : S_AOK;
   endtask

   // Expected outputs straight from the hazard rules and the current mode.
   function automatic logic [6:0] model_outs();
      bit lu, rt, mp, exc_m, exc_w;
      logic [6:0] o;
      lu = ((E_icode == 4'd5) || (E_icode == 4'hB)) && (E_dstM != 4'hF) &&
           ((E_dstM == d_srcA) || (E_dstM == d_srcB));
      rt = (D_icode == 4'd9) || (E_icode == 4'd9) || (M_icode == 4'd9);
      mp = (E_icode == 4'd7) && !e_cond;
      exc_m = (m_status != 2'd0);
      exc_w = (W_status != 2'd0);
      if (mdl_init) return OUT_INIT;
      if (mdl_halted) return OUT_HALT;
      o[6] = lu | rt;
      o[5] = lu;
      o[4] = mp | (rt & !lu);
      o[3] = mp | lu;
      o[2] = exc_m | exc_w | mdl_drain;
      o[1] = exc_w;
      o[0] = (E_icode == 4'd6) && !exc_m && !exc_w && !mdl_drain;
      return o;
   endfunction

   task automatic model_tick();
      if (mdl_init) begin
         mdl_init = 0;
      end else if (!mdl_halted) begin
         if (W_status != 2'd0) begin
            mdl_halted = 1; mdl_drain = 0; mdl_code = W_status;
         end else if (m_status != 2'd0) begin
            mdl_drain = 1;
         end
      end
   endtask

   task automatic cycle_model(input string name);
      #1;
      check(name, 16'({outs, halted, halt_code}), 16'({model_outs(), mdl_halted, mdl_code}));
      model_tick();
   endtask

   // Called between a negedge and the next posedge; leaves the DUT in its INIT cycle ticked.
   task automatic do_reset(input string name);
      #2;
      rst_n = 1'b0;
      #1;
      check({name, "_async"}, 16'({outs, halted, halt_code}), 16'({OUT_INIT, 1'b0, 2'b00}));
      check({name, "_state"}, 16'(dbg_state), 16'd0);
      mdl_init = 1; mdl_drain = 0; mdl_halted = 0; mdl_code = 2'd0;
      @(negedge clk);
      rst_n = 1'b1;
      set_nop();
      cycle_model({name, "_init_cycle"});
   endtask

   initial begin
      int halt_cycles;
      set_nop();
      @(negedge clk);
      do_reset("reset");
      @(negedge clk);
      set_nop();
      #1;
      check("run_after_reset", 16'({outs, halted}), 16'd0);
      check("run_state", 16'(dbg_state), 16'd1);
      model_tick();

`ifdef PIPE_CTRL_PERF_EN
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         set_nop(); E_icode = I_MRMOVQ; E_dstM = 4'd3; d_srcA = 4'd3;
         cycle_model("perf_lu");
      end
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         set_nop(); E_icode = I_JXX; e_cond = 1'b0;
         cycle_model("perf_mp");
      end
      @(negedge clk);
      set_nop();
      #1;
      check("perf_stall_4", 16'(perf_stall), 16'd4);
      check("perf_mispred_2", 16'(perf_mispred), 16'd2);
      model_tick();
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         set_nop(); E_icode = I_POPQ; E_dstM = 4'd2; d_srcB = 4'd2;
         cycle_model("perf_sat_lu");
      end
      @(negedge clk);
      set_nop();
      #1;
      check("perf_stall_sat", 16'(perf_stall), 16'hF);
      model_tick();
`endif

      tbl[0]  = mkv(4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h1, 7'b0000000);
      tbl[1]  = mkv(4'h2, 4'h3, 4'hF, 4'h5, 4'h3, 1'b1, 4'h1, 7'b1101000);
      tbl[2]  = mkv(4'h2, 4'h3, 4'hF, 4'h5, 4'hF, 1'b1, 4'h1, 7'b0000000);
      tbl[3]  = mkv(4'h2, 4'h1, 4'h4, 4'hB, 4'h4, 1'b1, 4'h1, 7'b1101000);
      tbl[4]  = mkv(4'h9, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h1, 7'b1010000);
      tbl[5]  = mkv(4'h1, 4'hF, 4'hF, 4'h9, 4'hF, 1'b1, 4'h1, 7'b1010000);
      tbl[6]  = mkv(4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h9, 7'b1010000);
      tbl[7]  = mkv(4'h9, 4'h3, 4'hF, 4'h5, 4'h3, 1'b1, 4'h1, 7'b1101000);
      tbl[8]  = mkv(4'h1, 4'hF, 4'hF, 4'h7, 4'hF, 1'b0, 4'h1, 7'b0011000);
      tbl[9]  = mkv(4'h1, 4'hF, 4'hF, 4'h7, 4'hF, 1'b1, 4'h1, 7'b0000000);
      tbl[10] = mkv(4'h9, 4'hF, 4'hF, 4'h7, 4'hF, 1'b0, 4'h1, 7'b1011000);
      tbl[11] = mkv(4'h1, 4'hF, 4'hF, 4'h6, 4'hF, 1'b1, 4'h1, 7'b0000001);
      tbl[12] = mkv(4'h1, 4'h2, 4'h4, 4'h5, 4'h3, 1'b1, 4'h1, 7'b0000000);

      foreach (tbl[i]) begin
         @(negedge clk);
         apply_vec(tbl[i]);
         #1;
         check($sformatf("vec%0d", i), 16'(outs), 16'(tbl[i].exp));
         model_tick();
      end

      // exception in M, one DRAIN cycle with clean status, then W reaches halt
      @(negedge clk);
      set_nop(); E_icode = I_OPQ; m_status = S_ADR;
      #1;
      check("exc_m_outs", 16'({outs, halted}), 16'({7'b0000100, 1'b0}));
      model_tick();
      @(negedge clk);
      set_nop(); E_icode = I_OPQ;
      #1;
      check("drain_outs", 16'({outs, halted}), 16'({7'b0000100, 1'b0}));
      check("drain_state", 16'(dbg_state), 16'd2);
      model_tick();
      @(negedge clk);
      set_nop(); E_icode = I_OPQ; W_status = S_ADR;
      #1;
      check("drain_w_exc", 16'({outs, halted}), 16'({7'b0000110, 1'b0}));
      model_tick();
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         rand_inputs();
         #1;
         check($sformatf("halt_sticky%0d", i), 16'({outs, halted, halt_code}),
               16'({OUT_HALT, 1'b1, 2'd2}));
         model_tick();
      end
      do_reset("rst_halted");

      // direct RUN->HALTED on W status
      @(negedge clk);
      set_nop(); W_status = S_INS;
      #1;
      check("run_w_exc", 16'({outs, halted}), 16'({7'b0000110, 1'b0}));
      model_tick();
      @(negedge clk);
      set_nop();
      #1;
      check("direct_halt", 16'({outs, halted, halt_code}), 16'({OUT_HALT, 1'b1, 2'd3}));
      model_tick();
      do_reset("rst_after_direct");

      // reset while draining
      @(negedge clk);
      set_nop(); m_status = S_HLT;
      cycle_model("enter_drain");
      @(negedge clk);
      set_nop();
      cycle_model("in_drain");
      do_reset("rst_drain");

      halt_cycles = 0;
      for (int i = 0; i < 1500; i++) begin
         @(negedge clk);
         rand_inputs();
         cycle_model($sformatf("rand%0d", i));
         if (mdl_halted) halt_cycles++;
         if (halt_cycles > 4 || $urandom_range(0, 299) == 0) begin
            halt_cycles = 0;
            do_reset($sformatf("rand_rst%0d", i));
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
